// File: rtl/fetch_controller.sv
// Fetch sequencer in front of the instruction buffer: owns the fetch PC, throttles requests
// against buffer occupancy and memory requests in flight, and drops stale responses after a redirect.
module fetch_controller #(
    parameter int unsigned BUFFER_SIZE     = 8,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [31:0] RESET_ADDRESS   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_address_i,
    input  logic        halt_i,
    input  logic        predict_taken_i,
    input  logic [31:0] predict_target_i,
    input  logic        fetch_ready_i,
    input  logic        fetch_valid_i,
    input  logic        buf_read_i,
    output logic        fetch_request_o,
    output logic [31:0] fetch_address_o,
    output logic        buf_write_address_o,
    output logic        buf_write_speculative_o,
    output logic [31:0] buf_address_o,
    output logic        buf_speculative_o,
    output logic        buf_write_instruction_o,
    output logic        buf_flush_o,
    output logic        halted_o
);
    localparam int unsigned OCC_W  = $clog2(BUFFER_SIZE) + 1;
    localparam int unsigned PEND_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OCC_W-1:0]  OCC_MAX  = OCC_W'(BUFFER_SIZE);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_OUTSTANDING);
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t            state_q;
    logic              halted_q;
    logic [31:0]       pc_q, pc_d;
    logic [OCC_W-1:0]  occ_q, occ_d, occ_e;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [PEND_W-1:0] kill_q, kill_d;
    logic [31:0]       req_addr;
    logic              issue, pop, drop, drain_done;

    always_comb begin
        occ_e    = redirect_i ? '0 : occ_q;
        req_addr = redirect_i ? redirect_address_i : pc_q;

        fetch_request_o = rst_n_i && (state_q == RUN) && !halt_i
                          && (occ_e < OCC_MAX) && (pend_q < PEND_MAX);
        issue = fetch_request_o && fetch_ready_i;

        // A redirect flushes the buffer, so the read that decode does in that cycle is void.
        pop  = buf_read_i && !redirect_i && (occ_q != '0);
        // Responses landing in the redirect cycle belong to the flushed stream as well.
        drop = fetch_valid_i && (redirect_i || (kill_q != '0));

        fetch_address_o         = req_addr;
        buf_address_o           = req_addr;
        buf_write_address_o     = issue;
        buf_write_speculative_o = issue;
        buf_speculative_o       = rst_n_i && predict_taken_i && !redirect_i;
        buf_write_instruction_o = rst_n_i && fetch_valid_i && !drop;
        buf_flush_o             = rst_n_i && redirect_i;
        halted_o                = halted_q;

        pc_d = pc_q;
        if (issue) begin
            pc_d = (predict_taken_i && !redirect_i) ? predict_target_i : req_addr + 32'd4;
        end else if (redirect_i) begin
            pc_d = redirect_address_i;
        end

        occ_d  = occ_e + OCC_W'(issue) - OCC_W'(pop);
        pend_d = pend_q + PEND_W'(issue) - PEND_W'(fetch_valid_i);

        if (redirect_i) begin
            kill_d = pend_q - PEND_W'(fetch_valid_i);
        end else begin
            kill_d = kill_q - PEND_W'(fetch_valid_i && (kill_q != '0));
        end

        drain_done = (pend_q == '0) || ((pend_q == PEND_ONE) && fetch_valid_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
            pc_q     <= RESET_ADDRESS;
            occ_q    <= '0;
            pend_q   <= '0;
            kill_q   <= '0;
        end else begin
            pc_q   <= pc_d;
            occ_q  <= occ_d;
            pend_q <= pend_d;
            kill_q <= kill_d;
            unique case (state_q)
                RUN: begin
                    if (halt_i) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!halt_i) begin
                        state_q <= RUN;
                    end else if (drain_done) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!halt_i) begin
                        state_q  <= RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: expected issues/responses are queued per scenario and a
// negedge monitor pops and compares them whenever the DUT issues or memory responds.
module tb_fetch_controller;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_address_i = '0;
    logic        halt_i = 1'b0;
    logic        predict_taken_i = 1'b0;
    logic [31:0] predict_target_i = '0;
    logic        fetch_ready_i = 1'b0;
    logic        fetch_valid_i = 1'b0;
    logic        buf_read_i = 1'b0;
    logic        fetch_request_o;
    logic [31:0] fetch_address_o;
    logic        buf_write_address_o;
    logic        buf_write_speculative_o;
    logic [31:0] buf_address_o;
    logic        buf_speculative_o;
    logic        buf_write_instruction_o;
    logic        buf_flush_o;
    logic        halted_o;

    fetch_controller dut (
        .clk_i                   (clk_i),
        .rst_n_i                 (rst_n_i),
        .redirect_i              (redirect_i),
        .redirect_address_i      (redirect_address_i),
        .halt_i                  (halt_i),
        .predict_taken_i         (predict_taken_i),
        .predict_target_i        (predict_target_i),
        .fetch_ready_i           (fetch_ready_i),
        .fetch_valid_i           (fetch_valid_i),
        .buf_read_i              (buf_read_i),
        .fetch_request_o         (fetch_request_o),
        .fetch_address_o         (fetch_address_o),
        .buf_write_address_o     (buf_write_address_o),
        .buf_write_speculative_o (buf_write_speculative_o),
        .buf_address_o           (buf_address_o),
        .buf_speculative_o       (buf_speculative_o),
        .buf_write_instruction_o (buf_write_instruction_o),
        .buf_flush_o             (buf_flush_o),
        .halted_o                (halted_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic        spec;
    } iss_t;

    iss_t exp_issue[$];
    bit   exp_resp[$];
    int   checks = 0;
    int   passes = 0;
    int   mem_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_iss(input logic [31:0] a, input logic s);
        iss_t e;
        e.addr = a;
        e.spec = s;
        exp_issue.push_back(e);
    endtask

    // Memory answers in order, one response per cycle, whenever not held off.
    task automatic step(input logic rdy = 0, input logic hold = 0, input logic rd = 0,
                        input logic hlt = 0, input logic redir = 0, input logic [31:0] raddr = 0,
                        input logic pt = 0, input logic [31:0] ptgt = 0);
        @(posedge clk_i);
        #1;
        fetch_ready_i      = rdy;
        fetch_valid_i      = !hold && (mem_cnt > 0);
        buf_read_i         = rd;
        halt_i             = hlt;
        redirect_i         = redir;
        redirect_address_i = raddr;
        predict_taken_i    = pt;
        predict_target_i   = ptgt;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 20 && mem_cnt > 0; i++) step(0);
        chk("drained_before_reset", mem_cnt, 0);
        rst_n_i = 1'b0;
        step(0);
        step(0);
        rst_n_i = 1'b1;
    endtask

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (fetch_request_o && fetch_ready_i) begin
                if (exp_issue.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_issue: got address %h expected no request", fetch_address_o);
                end else begin
                    iss_t e;
                    e = exp_issue.pop_front();
                    chk("issue_addr", fetch_address_o, e.addr);
                    chk("issue_buf_addr", buf_address_o, e.addr);
                    chk("issue_spec", buf_speculative_o, e.spec);
                    chk("issue_buf_write", buf_write_address_o && buf_write_speculative_o, 1);
                end
                mem_cnt++;
            end
            if (fetch_valid_i) begin
                if (exp_resp.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_response: got write %b expected no response", buf_write_instruction_o);
                end else begin
                    bit r;
                    r = exp_resp.pop_front();
                    chk("resp_write", buf_write_instruction_o, r);
                end
                mem_cnt--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        step(0);
        step(0);
        @(negedge clk_i);
        chk("rst_request", fetch_request_o, 0);
        chk("rst_halted", halted_o, 0);
        chk("rst_flush", buf_flush_o, 0);
        chk("rst_write_instr", buf_write_instruction_o, 0);
        chk("rst_write_addr", buf_write_address_o, 0);

        // Fill the buffer, then one read re-enables one issue a cycle later
        do_reset();
        @(negedge clk_i);
        chk("first_req", fetch_request_o, 1);
        chk("first_addr", fetch_address_o, 32'h0);
        for (int i = 0; i < 8; i++) begin
            push_iss(32'(4 * i), 1'b0);
            exp_resp.push_back(1'b1);
        end
        repeat (10) step(1);
        @(negedge clk_i);
        chk("full_no_request", fetch_request_o, 0);
        chk("full_issue_count", exp_issue.size(), 0);
        push_iss(32'd32, 1'b0);
        exp_resp.push_back(1'b1);
        step(1, 0, 1);
        @(negedge clk_i);
        chk("full_read_same_cycle", fetch_request_o, 0);
        step(1);
        @(negedge clk_i);
        chk("req_after_read", fetch_request_o, 1);
        step(1);
        @(negedge clk_i);
        chk("full_again", fetch_request_o, 0);

        // Outstanding limit with responses held off
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_iss(32'(4 * i), 1'b0);
            exp_resp.push_back(1'b1);
        end
        repeat (6) step(1, 1);
        @(negedge clk_i);
        chk("max_out_no_request", fetch_request_o, 0);
        chk("max_out_left", exp_issue.size(), 1);
        step(1, 0);
        @(negedge clk_i);
        chk("release_same_cycle", fetch_request_o, 0);
        step(1, 1);
        @(negedge clk_i);
        chk("release_next_req", fetch_request_o, 1);
        repeat (3) step(1, 1);
        @(negedge clk_i);
        chk("max_out_again", fetch_request_o, 0);
        chk("max_out_one_more", exp_issue.size(), 0);

        // Redirect with three requests in flight
        do_reset();
        push_iss(32'h0, 1'b0);
        push_iss(32'h4, 1'b0);
        push_iss(32'h8, 1'b0);
        push_iss(32'h100, 1'b0);
        exp_resp.push_back(1'b0);
        exp_resp.push_back(1'b0);
        exp_resp.push_back(1'b0);
        exp_resp.push_back(1'b1);
        repeat (3) step(1, 1);
        step(0, 1);
        step(1, 1, 0, 0, 1, 32'h100);
        @(negedge clk_i);
        chk("redirect_flush", buf_flush_o, 1);
        chk("redirect_req", fetch_request_o, 1);
        step(0, 1);
        @(negedge clk_i);
        chk("flush_one_cycle", buf_flush_o, 0);
        repeat (6) step(0);
        @(negedge clk_i);
        chk("redirect_resp_done", exp_resp.size(), 0);

        // Predicted-taken branch at 0x8
        do_reset();
        push_iss(32'h0, 1'b0);
        push_iss(32'h4, 1'b0);
        push_iss(32'h8, 1'b1);
        push_iss(32'h40, 1'b0);
        repeat (4) exp_resp.push_back(1'b1);
        step(1);
        step(1);
        step(1, 0, 0, 0, 0, 32'h0, 1, 32'h40);
        @(negedge clk_i);
        chk("spec_bit_at_8", buf_speculative_o, 1);
        step(1);
        @(negedge clk_i);
        chk("predicted_target", fetch_address_o, 32'h40);
        repeat (3) step(0);

        // PC wrap at the top of the address space
        push_iss(32'hFFFF_FFFC, 1'b0);
        push_iss(32'h0, 1'b0);
        exp_resp.push_back(1'b1);
        exp_resp.push_back(1'b1);
        step(1, 0, 0, 0, 1, 32'hFFFF_FFFC);
        step(1);
        @(negedge clk_i);
        chk("wrap_addr", fetch_address_o, 32'h0);
        repeat (3) step(0);

        // Halt with two outstanding, redirect while halted, resume
        do_reset();
        push_iss(32'h0, 1'b0);
        push_iss(32'h4, 1'b0);
        repeat (3) exp_resp.push_back(1'b1);
        step(1, 1);
        step(1, 1);
        step(1, 1, 0, 1);
        @(negedge clk_i);
        chk("halt_no_request", fetch_request_o, 0);
        step(1, 1, 0, 1);
        @(negedge clk_i);
        chk("drain_not_halted", halted_o, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        @(negedge clk_i);
        chk("halted_at_last_resp", halted_o, 0);
        step(1, 0, 0, 1);
        @(negedge clk_i);
        chk("halted_after_last", halted_o, 1);
        step(1, 0, 0, 1, 1, 32'h200);
        @(negedge clk_i);
        chk("halted_redirect_no_req", fetch_request_o, 0);
        step(1, 0, 0, 1);
        @(negedge clk_i);
        chk("still_halted", halted_o, 1);
        push_iss(32'h200, 1'b0);
        step(1);
        @(negedge clk_i);
        chk("release_cycle_no_req", fetch_request_o, 0);
        step(1);
        @(negedge clk_i);
        chk("resume_addr", fetch_address_o, 32'h200);
        chk("resume_not_halted", halted_o, 0);
        repeat (4) step(0);

        @(negedge clk_i);
        chk("final_issue_queue", exp_issue.size(), 0);
        chk("final_resp_queue", exp_resp.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the fetch unit around the instruction buffer. It owns the fetch program counter and issues in-order requests to instruction memory. It drives the buffer's address, speculative, instruction and flush commands, and limits buffer occupancy and outstanding memory requests so that no entry is overwritten. On a backend redirect it drops responses that are still in flight and restarts fetch at the target.

## Interface
- BUFFER_SIZE, 8, instruction buffer depth (power of two)
- MAX_OUTSTANDING, 4, maximum memory requests in flight (stale ones included)
- RESET_ADDRESS, 32'h00000000, PC after reset

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- redirect_i  in  1  backend flush/redirect
- redirect_address_i  in  32  redirect target
- halt_i  in  1  stop fetch (fence.i / WFI); level-sensitive
- predict_taken_i  in  1  predictor verdict for the current fetch address (combinational, same cycle)
- predict_target_i  in  32  predicted target
- fetch_ready_i  in  1  memory accepts request
- fetch_valid_i  in  1  memory response valid (in order, latency ≥1)
- buf_read_i  in  1  decode pops one buffer entry
- fetch_request_o  out  1  memory request
- fetch_address_o  out  32  request address
- buf_write_address_o  out  1  write the address and speculative bit into the buffer
- buf_write_speculative_o  out  1  equal to buf_write_address_o
- buf_address_o  out  32  equal to fetch_address_o
- buf_speculative_o  out  1  entry is a predicted-taken branch
- buf_write_instruction_o  out  1  memory response is written into the buffer
- buf_flush_o  out  1  buffer flush, equal to redirect_i
- halted_o  out  1  fetch is fully quiesced

## Operation
- Registers:
  - pc[31:0]
  - occupancy[$clog2(BUFFER_SIZE):0], the number of allocated buffer entries
  - pending[$clog2(MAX_OUTSTANDING):0], the number of requests in flight
  - kill[same width as pending], the number of in-flight requests that are stale
  - state
- States: RUN, DRAIN, HALTED.
  - RUN → DRAIN when halt_i=1.
  - DRAIN → HALTED when pending=0, or when pending=1 with fetch_valid_i=1.
  - HALTED → RUN when halt_i=0.
  - DRAIN → RUN when halt_i drops before the drain completes.
- Effective occupancy occ_e is 0 in a redirect cycle; otherwise it equals occupancy.
- fetch_request_o = (state==RUN) & !halt_i & (occ_e < BUFFER_SIZE) & (pending < MAX_OUTSTANDING).
- issue = fetch_request_o & fetch_ready_i.
- fetch_address_o and buf_address_o carry redirect_address_i when redirect_i=1; otherwise they carry pc.
- buf_write_address_o = buf_write_speculative_o = issue.
- buf_speculative_o = predict_taken_i & !redirect_i.
- Next PC on issue:
  - predict_target_i if predict_taken_i and not redirecting.
  - Otherwise the issued address + 4, wrapping modulo 2^32.
- Next PC with no issue: redirect_address_i if redirect_i; otherwise pc is held.
- Response handling:
  - A response with kill>0 is dropped: kill decrements and buf_write_instruction_o=0.
  - Otherwise buf_write_instruction_o=1.
  - Every response decrements pending.
- occupancy_next = occ_e + issue − (buf_read_i & !redirect_i).
  - When issue and a read happen in the same cycle, occupancy is unchanged.
- pending_next = pending + issue − fetch_valid_i.
- kill_next:
  - On redirect: pending − fetch_valid_i. Every older request becomes stale, and a response arriving in the redirect cycle is dropped.
  - Otherwise: kill − (fetch_valid_i & kill≠0).
- Redirect in RUN or DRAIN:
  - State is unchanged.
  - An issue in the redirect cycle, together with the buffer flush, lands in buffer entry 0.
- Redirect in HALTED: loads pc and state stays HALTED.
- halted_o = (state==HALTED).
- Design invariants: pending ≤ MAX_OUTSTANDING, kill ≤ pending, occupancy ≤ BUFFER_SIZE.

## Timing
- Reset values:
  - pc=RESET_ADDRESS, state=RUN, occupancy=pending=kill=0.
  - All command outputs are 0; halted_o=0.
  - fetch_request_o=1 in the first cycle after reset release, with fetch_address_o=RESET_ADDRESS.
- Reset mid-operation discards all counters immediately. Responses to pre-reset requests are the memory's responsibility.
- fetch_request_o, the fetch_address_o/buf_address_o mux, buf_flush_o, buf_write_* and buf_speculative_o are combinational. All other state is registered.
- Redirect-to-request latency is 0 cycles: the target is requested in the redirect cycle if the limits allow.
- Back-to-back issue reaches 1 request per cycle while fetch_ready_i=1 and the limits are not reached.
- Full boundary: when occupancy=BUFFER_SIZE, no request is made. A buf_read_i in that cycle re-enables requests in the next cycle, not the same cycle.

## Test plan
- Reset, fetch_ready_i=1 always, 1-cycle response, no reads:
  - Addresses 0, 4, 8, … through 28 are issued.
  - fetch_request_o drops after 8 issues and occupancy=8.
  - One buf_read_i lets address 32 issue in the next cycle.
- MAX_OUTSTANDING=4 with responses held off:
  - Exactly 4 issues occur.
  - Releasing one response allows exactly one new issue.
- Redirect to 0x100 with 3 in-flight requests:
  - The same cycle shows buf_flush_o=1 and a request at 0x100.
  - The next 3 responses give buf_write_instruction_o=0.
  - The 4th response (for 0x100) gives buf_write_instruction_o=1.
- predict_taken_i=1 with target 0x40 at PC 0x8:
  - buf_speculative_o=1 for address 0x8.
  - The next request is 0x40.
- PC 0xFFFFFFFC with no prediction: the next request is 0x00000000.
- Halt with 2 outstanding requests:
  - No new requests are issued.
  - halted_o rises the cycle after the 2nd response.
  - A redirect while HALTED loads pc.
  - Deasserting halt_i makes the first request go to the redirect target.
